// File: rtl/tetris_key_pkg.sv
// Shared scancodes, key indices and FSM encodings for the tetris keyboard front end.
package tetris_key_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_SPACE = 8'h29;

  localparam int NKEYS = 5;

  typedef enum logic [2:0] {LEFT, RIGHT, DOWN, ROTATE, DROP} key_e;
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} parse_e;
  typedef enum logic [1:0] {R_OFF, R_DELAY, R_REPEAT} rep_e;

endpackage

// File: rtl/tetris_key_repeat.sv
// One auto-repeat FSM: first action after D held ticks, then every P ticks.
// Only built when KEY_AUTOREPEAT_EN is defined.
module tetris_key_repeat
  import tetris_key_pkg::*;
#(
  parameter int D = 10,
  parameter int P = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_game,
  input  logic start,
  input  logic stop,
  output logic fire
);

  localparam int MAXV = (D > P) ? D : P;
  localparam int W    = $clog2(MAXV + 1);
  localparam logic [W-1:0] DL = W'(D);
  localparam logic [W-1:0] PL = W'(P);

  rep_e           state, state_nx;
  logic [W-1:0]   cnt, cnt_nx, cnt_inc;
  logic           hit;

  assign cnt_inc = (cnt == {W{1'b1}}) ? cnt : cnt + 1'b1;
  assign hit     = tick_game && (state != R_OFF) &&
                   (cnt_inc == ((state == R_DELAY) ? DL : PL));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= R_OFF;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // A fresh press restarts the delay; a release or a left/right takeover wins over counting.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (start) begin
      state_nx = R_DELAY;
      cnt_nx   = '0;
    end else if (stop) begin
      state_nx = R_OFF;
      cnt_nx   = '0;
    end else if (tick_game && state != R_OFF) begin
      if (hit) begin
        state_nx = R_REPEAT;
        cnt_nx   = '0;
      end else begin
        cnt_nx = cnt_inc;
      end
    end
  end

  always_comb fire = hit && !start && !stop;

endmodule

// File: rtl/tetris_key_ctrl.sv
// PS/2 set-2 scancode decoder producing tick-consumed action flags for tetris_game.
// Auto-repeat of left/right/down is compiled in only with KEY_AUTOREPEAT_EN.
module tetris_key_ctrl
  import tetris_key_pkg::*;
#(
  parameter int DAS_TICKS  = 10,
  parameter int ARR_TICKS  = 3,
  parameter int SOFT_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_game,
  input  logic       code_valid,
  input  logic [7:0] code_byte,
  output logic       key_left,
  output logic       key_right,
  output logic       key_down,
  output logic       key_rotate,
  output logic       key_drop
);

  parse_e             state, state_nx;
  logic               is_make, is_brk, is_ext, hit;
  key_e               kidx;
  logic [NKEYS-1:0]   ksel, held, pend, mk, brk, clr, fire;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (code_valid) begin
      case (state)
        IDLE: begin
          if (code_byte == SC_EXT)      state_nx = EXT;
          else if (code_byte == SC_BRK) state_nx = BRK;
        end
        EXT:     state_nx = (code_byte == SC_BRK) ? EXT_BRK : IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    is_make = code_valid &&
              ((state == IDLE && code_byte != SC_EXT && code_byte != SC_BRK) ||
               (state == EXT  && code_byte != SC_BRK));
    is_brk  = code_valid && (state == BRK || state == EXT_BRK);
    is_ext  = (state == EXT) || (state == EXT_BRK);
  end

  // Unmapped codes still walk the parser back to IDLE; they just select no key.
  always_comb begin
    hit  = 1'b1;
    kidx = DROP;
    if (is_ext) begin
      case (code_byte)
        SC_LEFT:  kidx = LEFT;
        SC_RIGHT: kidx = RIGHT;
        SC_DOWN:  kidx = DOWN;
        SC_UP:    kidx = ROTATE;
        default:  hit  = 1'b0;
      endcase
    end else begin
      hit = (code_byte == SC_SPACE);
    end
  end

  assign ksel = hit ? (NKEYS'(1) << kidx) : '0;
  assign mk   = is_make ? (ksel & ~held) : '0;
  assign brk  = is_brk  ? ksel : '0;
  // A new left/right press takes over from the other direction.
  assign clr  = {{(NKEYS-2){1'b0}}, mk[LEFT], mk[RIGHT]};

  always_ff @(posedge clk) begin
    if (rst) begin
      held <= '0;
      pend <= '0;
    end else begin
      held <= (held | mk) & ~brk;
      pend <= (pend & ~{NKEYS{tick_game}} & ~clr) | mk | fire;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  for (genvar i = 0; i < 3; i++) begin : g_rep
    localparam int D = (i == int'(DOWN)) ? SOFT_TICKS : DAS_TICKS;
    localparam int P = (i == int'(DOWN)) ? SOFT_TICKS : ARR_TICKS;
    tetris_key_repeat #(.D(D), .P(P)) u_rep (
      .clk       (clk),
      .rst       (rst),
      .tick_game (tick_game),
      .start     (mk[i]),
      .stop      (brk[i] | clr[i]),
      .fire      (fire[i])
    );
  end
  assign fire[NKEYS-1:3] = '0;
`else
  logic unused_cfg;
  assign unused_cfg = ^{DAS_TICKS, ARR_TICKS, SOFT_TICKS};
  assign fire = '0;
`endif

  assign key_left   = pend[LEFT];
  assign key_right  = pend[RIGHT];
  assign key_down   = pend[DOWN];
  assign key_rotate = pend[ROTATE];
  assign key_drop   = pend[DROP];

endmodule

// File: tb/tb_tetris_key_ctrl.sv
// Directed and random scancode streams checked against a key-level behavioural model.
module tb_tetris_key_ctrl;

  localparam int DAS  = 10;
  localparam int ARR  = 3;
  localparam int SOFT = 1;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_game = 1'b0;
  logic       code_valid = 1'b0;
  logic [7:0] code_byte = 8'h00;
  logic       key_left, key_right, key_down, key_rotate, key_drop;
  wire  [4:0] outs = {key_drop, key_rotate, key_down, key_right, key_left};

  int n_chk = 0;
  int n_err = 0;
  int acts[5];

  // model: prefix flags, held keys, pending actions, ticks counted since each press
  bit       m_ext, m_brk;
  bit [4:0] m_held, m_pend, m_act;
  int       m_nt[5];

  logic [7:0] tbl[8] = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h72, 8'h75, 8'h29, 8'h1C};

  tetris_key_ctrl #(.DAS_TICKS(DAS), .ARR_TICKS(ARR), .SOFT_TICKS(SOFT)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_game  (tick_game),
    .code_valid (code_valid),
    .code_byte  (code_byte),
    .key_left   (key_left),
    .key_right  (key_right),
    .key_down   (key_down),
    .key_rotate (key_rotate),
    .key_drop   (key_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // n-th counted tick after a press yields an action at n==D, then every P
  function automatic bit due(input int i, input int n);
    int d, p;
    d = (i == 2) ? SOFT : DAS;
    p = (i == 2) ? SOFT : ARR;
    return (n == d) || (n > d && ((n - d) % p) == 0);
  endfunction

  task automatic m_reset();
    m_ext = 0; m_brk = 0; m_held = '0; m_pend = '0; m_act = '0;
    for (int i = 0; i < 5; i++) m_nt[i] = 0;
  endtask

  task automatic model(input bit v, input logic [7:0] b, input bit t);
    int k;
    bit mk, br, e;
    bit [4:0] set, clr, start, brk, stop;
    k = -1; mk = 0; br = 0; e = 0;
    set = '0; clr = '0; start = '0; brk = '0;
    if (v) begin
      if (m_brk) begin br = 1; e = m_ext; m_ext = 0; m_brk = 0; end
      else if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE0 && !m_ext) m_ext = 1;
      else begin mk = 1; e = m_ext; m_ext = 0; end
    end
    if (mk || br) begin
      if (e) begin
        case (b)
          8'h6B: k = 0;
          8'h74: k = 1;
          8'h72: k = 2;
          8'h75: k = 3;
          default: k = -1;
        endcase
      end else if (b == 8'h29) k = 4;
    end
    if (k >= 0 && mk && !m_held[k]) begin
      start[k] = 1; set[k] = 1;
      if (k < 2) clr[1-k] = 1;
    end
    if (k >= 0 && br) brk[k] = 1;
    stop = brk | clr;
    for (int i = 0; i < 3; i++)
      if (REP && t && m_act[i] && !start[i] && !stop[i]) begin
        m_nt[i]++;
        if (due(i, m_nt[i])) set[i] = 1;
      end
    for (int i = 0; i < 5; i++) if (start[i]) m_nt[i] = 0;
    m_act  = (m_act & ~stop) | start;
    m_held = (m_held | start) & ~brk;
    m_pend = (m_pend & ~(t ? 5'h1F : 5'h00) & ~clr) | set;
  endtask

  task automatic cyc(input bit v, input logic [7:0] b, input bit t);
    code_valid = v; code_byte = b; tick_game = t;
    for (int i = 0; i < 5; i++) if (t && outs[i]) acts[i]++;
    @(posedge clk);
    model(v, b, t);
    #1;
    code_valid = 0; tick_game = 0;
    chk("cycle", outs, m_pend);
  endtask

  task automatic send(input logic [7:0] b); cyc(1, b, 0); endtask
  task automatic tick();  cyc(0, 8'h00, 1); endtask
  task automatic idle();  cyc(0, 8'h00, 0); endtask

  task automatic do_rst();
    rst = 1; code_valid = 0; tick_game = 0;
    @(posedge clk);
    m_reset();
    #1 rst = 0;
  endtask

  task automatic clr_acts();
    for (int i = 0; i < 5; i++) acts[i] = 0;
  endtask

  initial begin
    m_reset();
    clr_acts();
    do_rst();
    chk("reset", outs, 0);

    // single press/release of left
    send(8'hE0); send(8'h6B);
    chk("left_set", key_left, 1);
    tick();
    chk("left_consumed", key_left, 0);
    send(8'hE0); send(8'hF0); send(8'h6B); tick();
    chk("left_acts", acts[0], 1);
    chk("right_none", acts[1], 0);

    // left held through 20 ticks, then released
    clr_acts();
    send(8'hE0); send(8'h6B);
    for (int i = 0; i < 20; i++) begin tick(); idle(); end
    send(8'hE0); send(8'hF0); send(8'h6B);
    for (int i = 0; i < 5; i++) begin tick(); idle(); end
    chk("das_acts", acts[0], REP ? 5 : 1);

    // down held for 25 ticks
    clr_acts();
    send(8'hE0); send(8'h72);
    for (int i = 0; i < 25; i++) begin tick(); idle(); end
    chk("soft_acts", acts[2], REP ? 25 : 1);
    send(8'hE0); send(8'hF0); send(8'h72); tick();

    // drop released before the tick, then typematic repeats
    clr_acts();
    send(8'h29); send(8'hF0); send(8'h29);
    chk("drop_pending", key_drop, 1);
    tick(); tick();
    chk("drop_once", acts[4], 1);
    send(8'h29); send(8'h29); send(8'h29); tick(); tick();
    chk("drop_typematic", acts[4], 2);
    send(8'hF0); send(8'h29); tick();

    // left takes over from held right
    clr_acts();
    send(8'hE0); send(8'h74);
    send(8'hE0); send(8'h6B);
    chk("takeover_right", key_right, 0);
    chk("takeover_left", key_left, 1);
    tick();
    send(8'hE0); send(8'hF0); send(8'h6B);
    for (int i = 0; i < 12; i++) begin tick(); idle(); end
    chk("no_right_resume", acts[1], 0);
    chk("takeover_left_acts", acts[0], 1);
    send(8'hE0); send(8'hF0); send(8'h74); tick();

    // reset in the middle of an E0 prefix with left held
    send(8'hE0); send(8'h6B); send(8'hE0);
    do_rst();
    chk("rst_outs", outs, 0);
    send(8'h6B);
    chk("rst_base_6b", outs, 0);
    send(8'hE0); send(8'h6B);
    chk("rst_released", key_left, 1);
    tick();
    send(8'hE0); send(8'hF0); send(8'h6B);

    // make byte on the same edge as a tick
    send(8'hE0); cyc(1, 8'h6B, 1);
    chk("same_edge_set", key_left, 1);
    tick();
    chk("same_edge_then_clr", key_left, 0);
    send(8'hE0); send(8'hF0); send(8'h6B); tick();

    // random byte/tick stream
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 299) == 0) do_rst();
      else cyc($urandom_range(0, 2) != 0, tbl[$urandom_range(0, 7)], $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/tetris_key_ctrl.md
# tetris_key_ctrl

Keyboard front end for `tetris_game`. It decodes a stream of PS/2 set-2 scancode bytes into held/released key state, then turns that state into the game's `key_left`, `key_right`, `key_down`, `key_rotate` and `key_drop` inputs. Each action is presented so that every press and every auto-repeat step is consumed by exactly one `tick_game`. The block sits between the PS/2 byte receiver and `tetris_game`, and shares `tick_game` with it.

## Interface
Parameters:
- `DAS_TICKS`, default 10: ticks a left/right key is held before auto-repeat starts; must be ≥1.
- `ARR_TICKS`, default 3: ticks between left/right repeats; must be ≥1.
- `SOFT_TICKS`, default 1: delay and period of down-key repeat, in ticks; must be ≥1.

Ports:
- `clk`  in  1: system clock. One clock; all logic is on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `tick_game`  in  1: game tick strobe, one cycle wide. Same signal as the one driving `tetris_game`.
- `code_valid`  in  1: `code_byte` is valid this cycle.
- `code_byte`  in  8: scancode byte.
- `key_left`, `key_right`, `key_down`, `key_rotate`, `key_drop`  out  1 each: registered pending-action flags.

## Operation
- Parser FSM, advanced only when `code_valid` is high:
  - IDLE: E0 → EXT; F0 → BRK; any other byte → make(base code), stay in IDLE.
  - EXT: F0 → EXT_BRK; any other byte → make(extended code), go to IDLE.
  - BRK: any byte → break(base code), go to IDLE.
  - EXT_BRK: any byte → break(extended code), go to IDLE.
- Key map: E0 6B = left, E0 74 = right, E0 72 = down, E0 75 = rotate, base 29 (space) = drop. All other codes are ignored, but they still complete their prefix sequence.
- Make of a key that is not currently held:
  - sets `held`;
  - sets that key's pending flag;
  - clears the key's repeat counter and puts its repeat FSM into DELAY.
- Make of a key that is already held (typematic): ignored.
- Break: clears `held` and returns the repeat FSM to OFF. The pending flag is NOT cleared, so a press that is released before the next tick still produces its action.
- Left/right are mutually exclusive. A make of one clears the other's pending flag and forces the other's repeat FSM to OFF, while that key's `held` stays set. On release of the newer key, the older key does not resume.
- Repeat FSM for left, right and down. It counts only on cycles where `tick_game`=1 and the key is held.
  - OFF: no counting.
  - DELAY: count up; when the count reaches D, set pending, clear the count, go to REPEAT.
  - REPEAT: count up; when the count reaches P, set pending, clear the count.
  - Left/right use D=`DAS_TICKS`, P=`ARR_TICKS`. Down uses D=P=`SOFT_TICKS`.
- Rotate and drop never repeat: one action per make.
- Consumption: on the edge where `tick_game`=1, all pending flags clear. A same-edge set (new make, or a repeat count reaching its limit) overrides the clear.
- Counter width is $clog2(max(D,P)+1). Counters saturate and never wrap.

## Timing
- Reset value: all outputs 0, parser in IDLE, all `held` = 0, all repeat FSMs OFF, all counters 0.
- A make byte accepted at edge N makes the output high from cycle N+1.
- An output stays high until the first edge with `tick_game`=1, and goes low after that edge unless it is set again on the same edge.
- A byte that arrives while the parser is in a prefix state is consumed by the parser, never dropped.
- Reset asserted mid-sequence abandons a partial E0/F0 prefix and releases every key.
- `code_valid` and `tick_game` in the same cycle: both take effect; set wins over clear.

## Configuration
- `KEY_AUTOREPEAT_EN` defined: repeat FSMs and counters are compiled in, and behave as described above.
- `KEY_AUTOREPEAT_EN` undefined: no repeat logic. Every key, including down, yields exactly one action per make. Parameters are accepted but unused.

## Structure
- `tetris_key_pkg` holds:
  - scancode constants (`SC_EXT`=8'hE0, `SC_BRK`=8'hF0, `SC_LEFT`, `SC_RIGHT`, `SC_DOWN`, `SC_UP`, `SC_SPACE`);
  - the key index enum (LEFT, RIGHT, DOWN, ROTATE, DROP);
  - the parser state enum.
- Sub-module `tetris_key_repeat` implements one repeat FSM and its counter, with D and P as parameters. It is instantiated three times (left, right, down) inside the `KEY_AUTOREPEAT_EN` guard.

## Test plan
- Byte stream E0,6B; then 1 tick; then E0,F0,6B → `key_left` high after the 6B edge, low after the tick; exactly one action; no `key_right`.
- Left held with defaults, tick 1 the first tick after the press → actions on ticks 1, 11, 14, 17, 20 and on no other ticks. Break before tick 21 → no further actions.
- Down held for 25 ticks with `SOFT_TICKS`=1 → `key_down` high on every one of the 25 ticks.
- Byte 29 then F0,29, all before any tick → `key_drop` still consumed on the next tick, once only. Repeated 29 make bytes while held → no extra actions.
- Right make, then left make while right is held → `key_right` pending cleared, left pending set. After left is released, no right repeats.
- E0 followed by `rst`, then 6B → treated as base code 6B, ignored, all outputs 0. Make byte in the same cycle as `tick_game` → output remains high after that edge.
